serial_tx: RTL
==============

// Module: serial_tx
// PURPOSE
//   Serial byte transmitter, 1 bit per clk: start(0), DATA_W data bits LSB first,
//   [parity], STOP_BITS stop(1). Byte-side producer uses a valid/ready handshake.
//   A one-entry holding register allows back-to-back frames with no idle gap.
//   Drives the line sampled by the team's serial byte receiver FSM.
// PARAMETERS
//   DATA_W     8  data bits per frame (1..16)
//   STOP_BITS  1  stop bits per frame (1..4)
//   PARITY_ODD 0  1=odd parity, 0=even; used only when SERIAL_TX_PARITY_EN is defined
// PORTS
//   clk       in   1       clock, all state on posedge
//   reset     in   1       synchronous reset, active-high
//   in_byte   in   DATA_W  byte to send, sampled when in_valid && in_ready
//   in_valid  in   1       producer has a byte
//   in_ready  out  1       holding register empty (= !hold_full, from a flop)
//   out       out  1       serial line, registered, idles high
//   busy      out  1       FSM not in IDLE (frame on the line)
//   done      out  1       1-cycle pulse during the last stop-bit cycle
// BEHAVIOUR
// - Reset: state=IDLE, out=1, busy=0, done=0, hold_full=0, so in_ready=1. A reset
//   mid-frame aborts it and discards the held byte; out=1 in the next cycle.
// - Handshake: transfer when in_valid&&in_ready at posedge -> hold<=in_byte, hold_full<=1.
//   in_ready has no combinational path from in_valid. in_byte is don't-care otherwise.
// - FSM states: IDLE, START, DATA, PAR, STOP.
//   IDLE : hold_full -> START (shift<=hold, hold_full<=0); else stay. out=1.
//   START: out=0 for 1 cycle -> DATA; bit_cnt<=0.
//   DATA : out=shift[0]; shift>>=1; bit_cnt++; after DATA_W cycles -> PAR if the
//          macro is defined, else STOP.
//   PAR  : out=parity bit for 1 cycle -> STOP.
//   STOP : out=1 for STOP_BITS cycles. On the last cycle, done=1. If hold_full then,
//          -> START (reload, no gap); else -> IDLE.
// - Timing: accept in cycle k, FSM idle -> out low in cycle k+2. Data bit i in cycle
//   k+3+i. Frame = 1+DATA_W+[1]+STOP_BITS cycles. Throughput is 1 frame per frame-time
//   while in_valid stays high.
// - Hold is freed on the reload edge, so in_ready rises the cycle after reload. A
//   producer can load byte n+1 during frame n. Accepts are ignored while hold_full=1.
// - Counters: bit_cnt is $clog2(DATA_W+1) bits and stop_cnt is 3 bits. Both clear on
//   entry to their state and never wrap mid-state.
// - Registers are updated only on the transitions above. Illegal state -> IDLE, out=1.
// CONFIGURATION
//   SERIAL_TX_PARITY_EN defined: PAR state is inserted after data.
//     Parity bit = ^data for even, ~^data for odd (PARITY_ODD=1). Frame grows by 1.
//   Undefined: no PAR state and no parity logic. DATA goes directly to STOP.
// TESTING
//   1. Reset, in_valid=0 for 20 cycles -> out=1, busy=0, done=0, in_ready=1 throughout.
//   2. Send 8'hA5 (defaults) -> out = 0,1,0,1,0,0,1,0,1,1 from cycle k+2. done=1 on the
//      final 1. The receiver model reports out_byte=8'hA5, done.
//   3. Hold in_valid with 8'h00, 8'hFF, 8'h3C -> three 10-cycle frames with no idle
//      between them. in_ready low while hold is full.
//   4. Assert reset during data bit 4 of 8'h81 with a held 8'h55 -> out=1 the next
//      cycle, no frame for 8'h55, in_ready=1.
//   5. STOP_BITS=2, send 8'h01 -> 11-cycle frame. done is asserted only on the 2nd stop cycle.
//   6. SERIAL_TX_PARITY_EN, PARITY_ODD=0: 8'h07 -> parity bit 1; 8'h03 -> 0.
//      With PARITY_ODD=1 the bits invert.

Source files
------------

// File: rtl/serial_tx.sv
// Serial byte transmitter: start(0), DATA_W data bits LSB first, [parity], STOP_BITS stop(1); one-entry hold register.
// Parity bit is present only when SERIAL_TX_PARITY_EN is defined (PARITY_ODD selects odd/even).
module serial_tx #(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              done
);
    localparam int                CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [2:0]        LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic              ONE_STOP  = (STOP_BITS == 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    if (DATA_W < 1 || DATA_W > 16 || STOP_BITS < 1 || STOP_BITS > 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("serial_tx: parameter out of range");
    end

    state_t              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [2:0]          stop_cnt_q;
    logic                out_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                accept;
    logic                reload;

    assign in_ready = ~hold_full_q;
    assign out      = out_q;
    assign busy     = busy_q;
    assign done     = done_q;

    assign accept = in_valid & ~hold_full_q;
    // The held byte moves into the shifter either from idle or on the last stop cycle.
    assign reload = hold_full_q &
                    ((state_q == IDLE) || (state_q == STOP && stop_cnt_q == LAST_STOP));

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (reload) begin
            hold_full_d = 1'b0;
        end else if (accept) begin
            hold_d      = in_byte;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    localparam logic PODD = (PARITY_ODD != 0);
    logic par_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        state_q <= START;
                        shift_q <= hold_q;
                        out_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    state_q   <= DATA;
                    bit_cnt_q <= '0;
                    out_q     <= shift_q[0];
                    shift_q   <= shift_q >> 1;
`ifdef SERIAL_TX_PARITY_EN
                    par_q     <= shift_q[0] ^ PODD;
`endif
                end
                DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_q    <= PAR;
                        out_q      <= par_q;
`else
                        state_q    <= STOP;
                        out_q      <= 1'b1;
                        stop_cnt_q <= '0;
                        done_q     <= ONE_STOP;
`endif
                    end else begin
                        out_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                        par_q     <= par_q ^ shift_q[0];
`endif
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PAR: begin
                    state_q    <= STOP;
                    out_q      <= 1'b1;
                    stop_cnt_q <= '0;
                    done_q     <= ONE_STOP;
                end
`endif
                STOP: begin
                    if (stop_cnt_q == LAST_STOP) begin
                        done_q <= 1'b0;
                        if (hold_full_q) begin
                            state_q <= START;
                            shift_q <= hold_q;
                            out_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            out_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        stop_cnt_q <= stop_cnt_q + 3'd1;
                        // done is registered, so raise it one edge ahead of the final stop cycle.
                        done_q     <= (stop_cnt_q + 3'd1 == LAST_STOP);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
